// File: rtl/dmem_mmio.sv
// MEM-stage data memory: addr[31]=0 selects a byte-writable word RAM, addr[31]=1 an
// I/O page (synchronised inputs with change flags, output registers, cycle counter).
module dmem_mmio #(
  parameter int unsigned      MEM_AW    = 14,
  parameter int unsigned      N_IN      = 2,
  parameter int unsigned      IN_W      = 8,
  parameter int unsigned      N_OUT     = 1,
  parameter int unsigned      OUT_W     = 16,
  parameter logic [OUT_W-1:0] OUT_RESET = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            addr,
  input  logic                   we,
  input  logic [3:0]             be,
  input  logic [31:0]            wdata,
  input  logic                   re,
  output logic [31:0]            rdata,
  output logic                   rvalid,
  input  logic [N_IN*IN_W-1:0]   in_data,
  output logic [N_OUT*OUT_W-1:0] out_data
);

  localparam int unsigned DEPTH  = 2 ** MEM_AW;
  localparam int unsigned IN_IW  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned OUT_IW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic [31:0]       mem [DEPTH];
  logic [MEM_AW-1:0] ram_idx;
  logic              is_io;
  logic [9:0]        off_w;
  logic              in_hit, out_hit, stat_hit, cnt_hit, stat_rd;
  logic [IN_IW-1:0]  in_idx;
  logic [OUT_IW-1:0] out_idx;
  logic [31:0]       bmask;
  logic [31:0]       io_rd;

  logic [IN_W-1:0]   s1 [N_IN];
  logic [IN_W-1:0]   s2 [N_IN];
  logic [IN_W-1:0]   s3 [N_IN];
  logic [N_IN-1:0]   flag, flag_set;
  logic [OUT_W-1:0]  out_q [N_OUT];
  logic [31:0]       cycle_cnt;

  logic unused_addr;
  assign unused_addr = ^{addr[30:12], addr[1:0]};

  // Address decode; I/O offsets are handled as word offsets (addr[11:2]).
  assign ram_idx  = addr[MEM_AW+1:2];
  assign is_io    = addr[31];
  assign off_w    = addr[11:2];
  assign in_hit   = (off_w[9:8] == 2'b00) && (32'(off_w[7:0]) < N_IN);
  assign out_hit  = (off_w[9:8] == 2'b01) && (32'(off_w[7:0]) < N_OUT);
  assign stat_hit = (off_w == 10'h200);
  assign cnt_hit  = (off_w == 10'h201);
  assign in_idx   = off_w[IN_IW-1:0];
  assign out_idx  = off_w[OUT_IW-1:0];
  assign stat_rd  = re && is_io && stat_hit;
  assign bmask    = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

  always_comb begin
    io_rd = '0;
    if (in_hit)        io_rd = 32'(s2[in_idx]);
    else if (out_hit)  io_rd = 32'(out_q[out_idx]);
    else if (stat_hit) io_rd = 32'(flag);
    else if (cnt_hit)  io_rd = cycle_cnt;
  end

  always_comb begin
    flag_set = '0;
    for (int i = 0; i < N_IN; i++) flag_set[i] = (s2[i] != s3[i]);
  end

  // Word RAM: no reset on contents, byte-enabled write blocked while in reset.
  always_ff @(posedge clk) begin
    if (rst_n && we && !is_io) begin
      for (int k = 0; k < 4; k++)
        if (be[k]) mem[ram_idx][k*8 +: 8] <= wdata[k*8 +: 8];
    end
  end

  // Read port: non-blocking capture gives read-first behaviour for every target.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= re;
      if (re) rdata <= is_io ? io_rd : mem[ram_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < N_OUT; j++) out_q[j] <= OUT_RESET;
    end else if (we && is_io && out_hit) begin
      out_q[out_idx] <= OUT_W'((32'(out_q[out_idx]) & ~bmask) | (wdata & bmask));
    end
  end

  // Synchroniser chain plus previous-value stage; a fresh set beats a status clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IN; i++) begin
        s1[i] <= '0;
        s2[i] <= '0;
        s3[i] <= '0;
      end
      flag <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        s1[i] <= in_data[i*IN_W +: IN_W];
        s2[i] <= s1[i];
        s3[i] <= s2[i];
      end
      flag <= (stat_rd ? '0 : flag) | flag_set;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cycle_cnt <= '0;
    else        cycle_cnt <= cycle_cnt + 32'd1;
  end

  always_comb begin
    out_data = '0;
    for (int j = 0; j < N_OUT; j++) out_data[j*OUT_W +: OUT_W] = out_q[j];
  end

endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Parametrised data memory with a memory-mapped I/O region for the pipeline's MEM stage. Bit 31 of the byte address selects between an inferred single-port word RAM (bit 31 = 0) and an I/O page (bit 31 = 1). The I/O page provides N_IN synchronised input channels with change-detect flags, N_OUT byte-writable output registers and a free-running cycle counter. All reads, RAM or I/O, have a uniform one-cycle registered latency.

## Interface
- MEM_AW, 14: RAM word-address width; depth = 2^MEM_AW 32-bit words.
- N_IN, 2: input channels, 1..32.
- IN_W, 8: input channel width, 1..32.
- N_OUT, 1: output registers, 1..64.
- OUT_W, 16: output register width, 1..32.
- OUT_RESET, 0: reset value of every output register (OUT_W bits).

- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- addr  in  32  byte address; bits [1:0] ignored.
- we  in  1  write strobe.
- be  in  4  byte enables for writes; be[k] gates wdata[8k+7:8k].
- wdata  in  32  write data.
- re  in  1  read strobe.
- rdata  out  32  read data; valid when rvalid = 1.
- rvalid  out  1  high exactly one cycle after an accepted re.
- in_data  in  N_IN*IN_W  asynchronous inputs; channel i = bits [i*IN_W +: IN_W].
- out_data  out  N_OUT*OUT_W  output registers; register j = bits [j*OUT_W +: OUT_W].

## Operation
- Region select: addr[31] = 0 selects RAM, word index addr[MEM_AW+1:2]; upper bits 30..MEM_AW+2 are ignored, so the RAM aliases.
- RAM: byte-enabled write. A read in the same cycle as a write to the same word returns the old data (read-first). RAM contents are not reset.
- I/O page: addr[31] = 1; offset = addr[11:0].
  - 0x000 + 4i, i < N_IN: synchronised input i, zero-extended. Read-only; writes are ignored.
  - 0x400 + 4j, j < N_OUT: output register j, R/W. A write updates only the enabled bytes that fall within OUT_W; reads return the value zero-extended.
  - 0x800: status. Bit i = change flag i; upper bits read 0. Read-to-clear.
  - 0x804: cycle counter, 32 bits, increments every cycle, wraps 0xFFFFFFFF -> 0. Read-only.
  - Any other offset, or an index >= N_IN or >= N_OUT: reads 0, writes are ignored.
- Input path: two-flop synchroniser per channel (s1, s2), then a previous-value register s3. Change flag i sets when s2 != s3.
- Status read: rdata captures the pre-clear flags. The flags clear in the same edge, except any flag whose set condition is true that cycle; set wins.
- we and re may be asserted together at any address. Behaviour is read-first everywhere: a read of an output register being written returns the old value.
- re with no we: no side effects except the status clear.

## Timing
- Reset (rst_n = 0 at an edge):
  - rdata = 0, rvalid = 0, counter = 0.
  - Flags = 0; s1/s2/s3 = 0.
  - Every out_data register = OUT_RESET.
- Reset wins over concurrent we/re. A read pending at the edge where reset asserts is dropped: no rvalid follows.
- Read latency: re sampled at edge n; rdata/rvalid are valid after edge n+1. Back-to-back reads are allowed every cycle.
- rdata holds its last value when rvalid = 0.
- Write latency: the target is updated at the sampling edge. out_data reflects a write one cycle after we.
- Input latency: an in_data change is visible to reads after 2 edges, and raises its flag after 3 edges.
- Counter read at edge n returns the value held before edge n. Two consecutive reads differ by 1.

## Test plan
- Reset: hold rst_n = 0 for 3 cycles with we = re = 1 -> rvalid = 0, out_data all OUT_RESET, then a read of 0x80000804 returns a small count (0 or 1, as counted from reset release).
- RAM byte enables: write 0x11223344 to 0x00000010 with be = 4'hF, then 0xAABBCCDD with be = 4'b0101 -> a read returns 0x11BB33DD one cycle after re. A simultaneous read+write to the same word returns the prior value.
- Output register: with OUT_W = 16, write 0xDEADBEEF with be = 4'hF to 0x80000400 -> out_data[15:0] = 0xBEEF the next cycle; a read returns 0x0000BEEF. A write to 0x80000400 + 4*N_OUT leaves all outputs unchanged.
- Input sync and flags: change in_data ch1 from 0x00 to 0x5A -> a read of 0x80000004 returns 0x5A from the 2nd edge; status bit 1 = 1. Reading 0x80000800 returns 0x2, and an immediate second read returns 0x0.
- Set-vs-clear collision: toggle ch0 so its flag sets on the same edge as a status read -> that read returns the old flag, and a subsequent read still shows bit 0 = 1.
- Counter wrap and unmapped reads: force the counter near 0xFFFFFFFE and read it continuously -> sequence ...FFFE, FFFF, 0, 1. Reads of 0x80000FF0 return 0.
